// File: rtl/pager_pkg.sv
// Shared types and constants for the ALU result pager.
//   pager_state_e : EMPTY (nothing captured yet) / SHOW (holding a result)
//   alu_result_t  : captured ALU result payload (data + {z,o,c,n} flags)
//   BLANK/GLYPH_* : active-low seven-segment patterns used by the pager
package pager_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;

  // Bit positions inside the flags nibble
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [SEG_W-1:0] BLANK   = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_L = 7'b1000111;
  localparam logic [SEG_W-1:0] GLYPH_H = 7'b0001001;

  typedef enum logic {
    EMPTY = 1'b0,
    SHOW  = 1'b1
  } pager_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } alu_result_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low push button and emits a
// one-cycle pulse when the debounced level falls (button pressed).
//   clock, reset : system clock, async active-high reset
//   key_n        : raw button, asynchronous to clock
//   press        : registered one-cycle pulse per accepted press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchronizer, stability counter and falling-edge pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      deb_q  <= 1'b1;
      cnt_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      if (sync_q[1] != deb_q) begin
        if (cnt_q == LAST) begin
          deb_q <= sync_q[1];
          cnt_q <= '0;
          // Old level 1 means the new level is 0: a press
          press <= deb_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/seg7.sv
// Hex nibble to active-low seven-segment decoder (bit 6 = g ... bit 0 = a).
//   nibble : value to display
//   seg_c  : combinational segment drive, 0 = segment lit
module seg7
  import pager_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = BLANK;
    case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_pager.sv
// Captures one ALU result through valid/ready and pages it across the
// DE1-SoC seven-segment displays.
//   clock, reset       : system clock, async active-high reset
//   res_valid/res_data/res_flags/res_ready : result handshake ({z,o,c,n})
//   page_key_n         : raw active-low KEY for manual paging
//   auto_en            : enable periodic page toggling
//   hold               : freeze the held value and refuse new results
//   HEX0..HEX5         : registered active-low segment drives
//   page               : 0 = low half shown, 1 = high half shown
module alu_result_pager
  import pager_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SCROLL_TICKS    = 50_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic [FLAG_W-1:0] res_flags,
  output logic              res_ready,
  input  logic              page_key_n,
  input  logic              auto_en,
  input  logic              hold,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic [SEG_W-1:0]  HEX4,
  output logic [SEG_W-1:0]  HEX5,
  output logic              page
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SCROLL_TICKS - 1);
  localparam int unsigned      HALF_W    = DATA_W / 2;
  localparam int unsigned      DIGITS    = HALF_W / NIB_W;

  pager_state_e     state_q, state_d;
  alu_result_t      result_q;
  logic [CNT_W-1:0] scroll_q;
  logic             press;
  logic             capture;
  logic             showing;
  logic             scroll_run;
  logic             scroll_tick;
  logic [HALF_W-1:0] half;
  logic [FLAG_W-1:0] flag_nib;
  logic [SEG_W-1:0]  digit_seg [DIGITS];
  logic [SEG_W-1:0]  flag_seg;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key (
    .clock (clock),
    .reset (reset),
    .key_n (page_key_n),
    .press (press)
  );

  assign showing     = (state_q == SHOW);
  assign capture     = res_valid & res_ready;
  assign scroll_run  = showing & auto_en & ~hold;
  assign scroll_tick = scroll_run & (scroll_q == LAST_TICK);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state: any accepted result moves to (or stays in) SHOW
  always_comb begin
    state_d = state_q;
    if (capture) state_d = SHOW;
  end

  // Ready follows hold once something is shown; EMPTY always accepts
  always_comb begin
    res_ready = 1'b1;
    if (state_q == SHOW) res_ready = ~hold;
  end

  // Capture register, page bit and scroll counter; capture outranks paging
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      page     <= 1'b0;
      scroll_q <= '0;
    end else if (capture) begin
      result_q <= '{data: res_data, flags: res_flags};
      page     <= 1'b0;
      scroll_q <= '0;
    end else if (showing && (press || scroll_tick)) begin
      page     <= ~page;
      scroll_q <= '0;
    end else if (scroll_run) begin
      scroll_q <= scroll_q + CNT_W'(1);
    end
  end

  assign half     = page ? result_q.data[DATA_W-1:HALF_W] : result_q.data[HALF_W-1:0];
  assign flag_nib = {result_q.flags[FLAG_Z], result_q.flags[FLAG_O],
                     result_q.flags[FLAG_C], result_q.flags[FLAG_N]};

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    seg7 u_digit (
      .nibble (half[i*NIB_W +: NIB_W]),
      .seg_c  (digit_seg[i])
    );
  end

  seg7 u_flags (
    .nibble (flag_nib),
    .seg_c  (flag_seg)
  );

  // Display registers: blank until a result has been captured
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      HEX0 <= BLANK;
      HEX1 <= BLANK;
      HEX2 <= BLANK;
      HEX3 <= BLANK;
      HEX4 <= BLANK;
      HEX5 <= BLANK;
    end else if (!showing) begin
      HEX0 <= BLANK;
      HEX1 <= BLANK;
      HEX2 <= BLANK;
      HEX3 <= BLANK;
      HEX4 <= BLANK;
      HEX5 <= BLANK;
    end else begin
      HEX0 <= digit_seg[0];
      HEX1 <= digit_seg[1];
      HEX2 <= digit_seg[2];
      HEX3 <= digit_seg[3];
      HEX4 <= flag_seg;
      HEX5 <= page ? GLYPH_H : GLYPH_L;
    end
  end

endmodule

// File: tb/tb_alu_result_pager.sv
// Directed bench for alu_result_pager with a cycle-level reference model
// compared on every falling edge, plus literal spot checks.
module tb_alu_result_pager;

  localparam int unsigned DEB = 4;
  localparam int unsigned ST  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic [3:0]  res_flags = '0;
  logic        res_ready;
  logic        page_key_n = 1'b1;
  logic        auto_en = 1'b0;
  logic        hold = 1'b0;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        page;
  logic [6:0]  dut_hex [6];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  alu_result_pager #(
    .DEBOUNCE_CYCLES(DEB),
    .SCROLL_TICKS   (ST),
    .CNT_W          (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_ready  (res_ready),
    .page_key_n (page_key_n),
    .auto_en    (auto_en),
    .hold       (hold),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5),
    .page       (page)
  );

  always #5 clock = ~clock;

  assign dut_hex[0] = HEX0;
  assign dut_hex[1] = HEX1;
  assign dut_hex[2] = HEX2;
  assign dut_hex[3] = HEX3;
  assign dut_hex[4] = HEX4;
  assign dut_hex[5] = HEX5;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_show;
  logic [31:0] m_data;
  logic [3:0]  m_flags;
  bit          m_page;
  int          m_scroll;
  bit          k1, k2, m_deb, m_press;
  int          m_run;
  logic [6:0]  m_hex [6];

  always @(posedge clock or posedge reset) begin : model
    logic [15:0] half;
    bit ready, cap, tick, new_press;
    if (reset) begin
      m_show = 0; m_data = '0; m_flags = '0; m_page = 0; m_scroll = 0;
      k1 = 1; k2 = 1; m_deb = 1; m_press = 0; m_run = 0;
      for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
    end else begin
      // displays reflect the state held before this edge
      half = m_page ? m_data[31:16] : m_data[15:0];
      if (!m_show) begin
        for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
      end else begin
        for (int i = 0; i < 4; i++) m_hex[i] = seg_of(half[i*4 +: 4]);
        m_hex[4] = seg_of(m_flags);
        m_hex[5] = m_page ? 7'b0001001 : 7'b1000111;
      end
      ready = !m_show || !hold;
      cap   = res_valid && ready;
      tick  = m_show && auto_en && !hold && (m_scroll == ST - 1);
      if (cap) begin
        m_data = res_data; m_flags = res_flags; m_show = 1; m_page = 0; m_scroll = 0;
      end else if (m_show && (m_press || tick)) begin
        m_page = !m_page; m_scroll = 0;
      end else if (m_show && auto_en && !hold) begin
        m_scroll = m_scroll + 1;
      end
      // key: level must differ from the debounced level for DEB edges in a row
      new_press = 0;
      if (k2 != m_deb) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          new_press = (k2 == 0);
          m_deb = k2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_press = new_press;
      k2 = k1;
      k1 = page_key_n;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (started) begin
      check("res_ready", 32'(res_ready), 32'(!m_show || !hold));
      check("page", 32'(page), 32'(m_page));
      for (int i = 0; i < 6; i++) check($sformatf("HEX%0d", i), 32'(dut_hex[i]), 32'(m_hex[i]));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_digits(input string name, input logic [15:0] half);
    check({name, "_HEX0"}, 32'(HEX0), 32'(seg_of(half[3:0])));
    check({name, "_HEX1"}, 32'(HEX1), 32'(seg_of(half[7:4])));
    check({name, "_HEX2"}, 32'(HEX2), 32'(seg_of(half[11:8])));
    check({name, "_HEX3"}, 32'(HEX3), 32'(seg_of(half[15:12])));
  endtask

  logic saved_page;
  int   n;

  initial begin
    #1 reset = 1'b1;
    started = 1'b1;
    tick(2);
    reset = 1'b0;

    // 1: idle after reset, key press ignored while EMPTY
    tick(5);
    check("rst_HEX0", 32'(HEX0), 32'h7F);
    check("rst_HEX5", 32'(HEX5), 32'h7F);
    check("rst_ready", 32'(res_ready), 32'd1);
    check("rst_page", 32'(page), 32'd0);
    page_key_n = 1'b0; tick(10);
    page_key_n = 1'b1; tick(10);
    check("empty_press_HEX0", 32'(HEX0), 32'h7F);
    check("empty_press_page", 32'(page), 32'd0);

    // 2: first capture, visible one edge later
    res_valid = 1'b1; res_data = 32'hDEAD_BEEF; res_flags = 4'b1001;
    tick(1);
    res_valid = 1'b0;
    check("cap_lat_HEX0", 32'(HEX0), 32'h7F);
    tick(1);
    check("cap_HEX0", 32'(HEX0), 32'h0E);
    check("cap_HEX1", 32'(HEX1), 32'h06);
    check("cap_HEX2", 32'(HEX2), 32'h06);
    check("cap_HEX3", 32'(HEX3), 32'h03);
    check("cap_HEX4", 32'(HEX4), 32'h10);
    check("cap_HEX5", 32'(HEX5), 32'h47);
    check("cap_page", 32'(page), 32'd0);

    // 3: long press toggles once, short glitch ignored
    page_key_n = 1'b0; tick(10);
    page_key_n = 1'b1; tick(10);
    check("press_page", 32'(page), 32'd1);
    check("press_HEX0", 32'(HEX0), 32'h21);
    check("press_HEX1", 32'(HEX1), 32'h08);
    check("press_HEX2", 32'(HEX2), 32'h06);
    check("press_HEX3", 32'(HEX3), 32'h21);
    check("press_HEX5", 32'(HEX5), 32'h09);
    page_key_n = 1'b0; tick(2);
    page_key_n = 1'b1; tick(10);
    check("glitch_page", 32'(page), 32'd1);

    // 4: auto-scroll period, hold freezes and blocks capture
    auto_en = 1'b1;
    tick(7);
    check("scroll_pre_page", 32'(page), 32'd1);
    tick(1);
    check("scroll_page", 32'(page), 32'd0);
    tick(3);
    hold = 1'b1;
    tick(1);
    saved_page = page;
    tick(20);
    check("hold_page", 32'(page), 32'(saved_page));
    check("hold_ready", 32'(res_ready), 32'd0);
    res_valid = 1'b1; res_data = 32'h1234_5678; res_flags = 4'b0010;
    tick(5);
    check("hold_HEX0", 32'(HEX0), saved_page ? 32'h21 : 32'h0E);
    hold = 1'b0;
    tick(1);
    res_valid = 1'b0;
    check("unhold_page", 32'(page), 32'd0);
    tick(1);
    check_digits("unhold", 16'h5678);
    check("unhold_HEX4", 32'(HEX4), 32'h24);

    // 5: capture coinciding with a debounced press and a scroll tick
    n = 0;
    while (m_scroll != 1 && n < 20) begin
      tick(1);
      n++;
    end
    check("align_scroll", 32'(m_scroll), 32'd1);
    page_key_n = 1'b0;
    tick(6);
    res_valid = 1'b1; res_data = 32'h0000_00A5; res_flags = 4'b0110;
    tick(1);
    res_valid = 1'b0;
    page_key_n = 1'b1;
    check("coinc_page", 32'(page), 32'd0);
    tick(1);
    check_digits("coinc", 16'h00A5);
    check("coinc_HEX4", 32'(HEX4), 32'h02);
    tick(6);
    check("coinc_cnt_pre", 32'(page), 32'd0);
    tick(1);
    check("coinc_cnt_tick", 32'(page), 32'd1);

    // 6: reset in the middle of a debounce while page=1
    auto_en = 1'b0;
    page_key_n = 1'b0;
    tick(3);
    reset = 1'b1;
    #1;
    check("arst_HEX0", 32'(HEX0), 32'h7F);
    check("arst_HEX3", 32'(HEX3), 32'h7F);
    check("arst_HEX4", 32'(HEX4), 32'h7F);
    check("arst_HEX5", 32'(HEX5), 32'h7F);
    check("arst_page", 32'(page), 32'd0);
    check("arst_ready", 32'(res_ready), 32'd1);
    page_key_n = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    check("post_rst_page", 32'(page), 32'd0);
    check("post_rst_HEX5", 32'(HEX5), 32'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_pager.md
Name: alu_result_pager

Overview:
- Consumer side of the ALU result path on the DE1-SoC board.
- Accepts a 32-bit ALU result plus Z/O/C/N flags through a valid/ready handshake and holds it in a capture register.
- Pages the held value across the seven-segment displays: low half or high half on HEX3..HEX0, flags on HEX4, page glyph on HEX5.
- Page changes come from a debounced KEY press or from an optional auto-scroll timer.

Parameters:
- DEBOUNCE_CYCLES, 16: cycles the synchronized key must stay stable before a level change is accepted.
- SCROLL_TICKS, 50_000_000: cycles between automatic page toggles while auto_en=1.
- CNT_W, 32: width of the debounce and scroll counters. Must hold max(DEBOUNCE_CYCLES, SCROLL_TICKS).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- res_valid  in  1  ALU result valid
- res_data  in  32  ALU result
- res_flags  in  4  {z,o,c,n}; bit 3 = z
- res_ready  out  1  pager can accept a result
- page_key_n  in  1  raw KEY, active-low, asynchronous to clock
- auto_en  in  1  enable auto-scroll
- hold  in  1  freeze the displayed value (deassert ready)
- HEX0..HEX5  out  7 each  active-low segment drives
- page  out  1  0 = low half shown, 1 = high half shown

Behaviour:
- Reset values:
  - State is EMPTY; page = 0; res_ready = 1.
  - Data and flags capture registers = 0; both counters = 0.
  - Sync flops = 1; debounced key = 1.
  - All HEX outputs = 7'h7F (blank).
- States:
  - EMPTY: res_ready = 1; all HEX blank; key presses and scroll are ignored.
  - SHOW: res_ready = ~hold.
- Handshake:
  - Capture occurs on a rising edge where res_valid & res_ready.
  - res_data and res_flags are latched; state becomes SHOW; page = 0; scroll counter = 0.
  - No capture when res_ready = 0. The producer must hold valid.
  - A capture in SHOW overwrites the held value. No buffering beyond one entry.
- Latency: HEX outputs are registered. A capture at edge N is visible on HEX from edge N+1. A page change at edge N is also visible from edge N+1.
- Key path:
  - page_key_n passes through a two-flop synchronizer.
  - The debounce counter increments while the synced level differs from the debounced level, and clears otherwise.
  - At DEBOUNCE_CYCLES-1 the debounced level is updated.
  - A press is a 1->0 transition of the debounced level: one-cycle pulse.
  - Press in SHOW toggles page and clears the scroll counter.
- Auto-scroll:
  - In SHOW with auto_en=1 and hold=0, the scroll counter increments.
  - At SCROLL_TICKS-1 it toggles page and wraps to 0.
  - auto_en=0 or hold=1 holds the counter at its current value.
- Simultaneous events:
  - Capture together with a press or scroll tick: capture wins; page = 0; counter = 0.
  - Press together with a scroll tick: exactly one toggle; counter = 0.
- Display mapping (SHOW):
  - HEX3..HEX0 = seg7 of nibbles [15:0] when page=0, or [31:16] when page=1. Nibble 0 goes on HEX0.
  - HEX4 = seg7 of the flags nibble.
  - HEX5 = GLYPH_L when page=0, GLYPH_H when page=1.
- Reset mid-operation: returns immediately (asynchronously) to the reset values. A pending key press is discarded.

Decomposition:
- Shared package pager_pkg:
  - State enum {EMPTY, SHOW}.
  - Constants BLANK = 7'h7F, GLYPH_L = 7'b1000111, GLYPH_H = 7'b0001001.
  - Flag bit indices Z=3, O=2, C=1, N=0.
- One natural sub-module: key_debounce (synchronizer + debounce counter + press pulse, parameter DEBOUNCE_CYCLES).
- Existing seg7 is instantiated five times for the hex digits.

Test Plan (DEBOUNCE_CYCLES=4, SCROLL_TICKS=8):
1. Reset, then idle 5 cycles -> HEX0..HEX5 = 7'h7F, res_ready=1, page=0. Press key -> no change.
2. res_valid=1 with res_data=32'hDEAD_BEEF, res_flags=4'b1001 for one cycle -> next edge: HEX3..HEX0 show B,E,E,F (HEX0 = F), HEX4 shows 9, HEX5=GLYPH_L, page=0.
3. Hold page_key_n low 10 cycles -> exactly one toggle, page=1, HEX3..HEX0 show D,E,A,D. A 2-cycle low glitch -> no toggle.
4. auto_en=1 -> page toggles every 8 cycles. Assert hold=1 -> toggles stop and res_ready=0. res_valid with 32'h1234_5678 is ignored. Deassert hold -> captured, page=0.
5. Capture of 32'h0000_00A5 in the same cycle as a debounced press and a scroll tick -> page=0, counter=0, HEX1/HEX0 show A,5.
6. Assert reset mid-debounce while in SHOW, page=1 -> outputs blank immediately, state EMPTY, no toggle after reset release.
